csa_calc_responder: RTL and testbench
=====================================

Name: csa_calc_responder

Overview:
Responder end of the csa_calc request/ready/reset handshake. It accepts a request carrying an input word, a round count and an inter-round delay. It iterates a fixed accumulate round the requested number of times, then presents the 48-bit result with ready held until the initiator pulses reset. It sits behind the per-channel AXI register logic and serves as a drop-in calculation engine.

Parameters:
AXI_DATA_WIDTH, 32, width of times/delay words
ID, 8, engine identifier; low 8 bits seed the result high byte
CSA_CALC_IN_WIDTH, 40, input word width
CSA_CALC_OUT_WIDTH, 48, result width; must equal CSA_CALC_IN_WIDTH+8

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
csa_calc_logic_request  in  1  start pulse; sampled only in IDLE
csa_calc_logic_times  in  AXI_DATA_WIDTH  round count, latched on accepted request
csa_calc_logic_delay  in  AXI_DATA_WIDTH  idle cycles between rounds, latched on accepted request
csa_calc_logic_in  in  CSA_CALC_IN_WIDTH  input word, latched on accepted request
csa_calc_logic_reset  in  1  release/abort pulse
csa_calc_logic_inuse  out  1  high from accepted request until release/abort
csa_calc_logic_ready  out  1  result valid
csa_calc_logic_out  out  CSA_CALC_OUT_WIDTH  result

Behaviour:
- Reset: state=IDLE. inuse=0, ready=0, out=0. All counters and latches are 0.
- Registered outputs only; no combinational path from input to output.
- States: IDLE, RUN, WAIT, DONE.
- IDLE + request=1 + reset=0:
  - Latch in, times and delay.
  - acc <= {ID[7:0], in}; rcnt <= 0; inuse <= 1.
  - Next state: DONE if times==0, else RUN.
- RUN: one round per cycle.
  - acc <= acc + zero-extended in (mod 2^48); rcnt <= rcnt+1.
  - If rcnt+1==times, go to DONE.
  - Otherwise go to WAIT with dcnt<=0 if delay!=0, else stay in RUN.
- WAIT: dcnt <= dcnt+1; when dcnt+1==delay, go to RUN.
- DONE: out=acc and ready=1, both held stable until csa_calc_logic_reset.
- Result: out = {ID,in} + times*in, mod 2^48.
- Latency: from the request-sampling edge to ready=1 is times+1 edges + (times-1)*delay edges. With times=0 the latency is 1 edge (ready appears one cycle after the request).
- csa_calc_logic_reset=1 in any state:
  - Next state IDLE; ready <= 0; inuse <= 0.
  - out keeps its last value.
  - Takes priority over a simultaneous request, which is dropped.
- A request outside IDLE is ignored. Latched values are unaffected by input changes after acceptance.
- Counters are AXI_DATA_WIDTH wide. times=2^32-1 must complete without wrap; comparisons are equality on full width.
- Asynchronous rst mid-operation returns to the reset values immediately. A request in the first cycle after rst deasserts is accepted normally.

Optional Feature:
Macro CSA_CALC_CYCLE_COUNT_EN.
- Defined:
  - Adds output csa_calc_logic_cycles [AXI_DATA_WIDTH-1:0].
  - Cleared on the accepting request edge; increments every cycle in RUN or WAIT.
  - Frozen in DONE and IDLE; saturates at all-ones.
  - Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- ID=8, in=40'h1111111111, times=100, delay=0, one request pulse → ready rises 101 edges later; out=48'h0EBBBBBBBBB5; inuse high throughout.
- Same request with times=0 → ready one cycle after the request; out=48'h081111111111.
- in=40'h1, times=3, delay=2 → ready after 4+4=8 edges; out=48'h080000000004; cycles counter=7 when the macro is enabled.
- Pulse csa_calc_logic_reset while in RUN (times=100, at round 10) → next cycle IDLE, inuse=0, ready=0. A new request with times=1 then gives out={08,in}+in.
- Pulse request repeatedly during RUN and change in/times → result equals the value for the originally latched operands. Request and reset asserted together in IDLE → stays in IDLE, inuse=0.
- Assert rst for 1 ns mid-WAIT → all outputs 0 immediately. Back-to-back loop of request → ready → reset with in incrementing → each out matches the formula.

Source files
------------

// File: rtl/csa_calc_responder_if.sv
// Request/ready/reset handshake bundle between a csa_calc initiator and responder.
// The cycle-count output exists only when CSA_CALC_CYCLE_COUNT_EN is defined.
`timescale 1ns/1ps
interface csa_calc_responder_if #(
    parameter int AXI_DATA_WIDTH     = 32,
    parameter int CSA_CALC_IN_WIDTH  = 40,
    parameter int CSA_CALC_OUT_WIDTH = 48
);
    logic                          csa_calc_logic_request;
    logic [AXI_DATA_WIDTH-1:0]     csa_calc_logic_times;
    logic [AXI_DATA_WIDTH-1:0]     csa_calc_logic_delay;
    logic [CSA_CALC_IN_WIDTH-1:0]  csa_calc_logic_in;
    logic                          csa_calc_logic_reset;
    logic                          csa_calc_logic_inuse;
    logic                          csa_calc_logic_ready;
    logic [CSA_CALC_OUT_WIDTH-1:0] csa_calc_logic_out;
`ifdef CSA_CALC_CYCLE_COUNT_EN
    logic [AXI_DATA_WIDTH-1:0]     csa_calc_logic_cycles;

    modport master (
        output csa_calc_logic_request, csa_calc_logic_times, csa_calc_logic_delay,
               csa_calc_logic_in, csa_calc_logic_reset,
        input  csa_calc_logic_inuse, csa_calc_logic_ready, csa_calc_logic_out,
               csa_calc_logic_cycles
    );
    modport slave (
        input  csa_calc_logic_request, csa_calc_logic_times, csa_calc_logic_delay,
               csa_calc_logic_in, csa_calc_logic_reset,
        output csa_calc_logic_inuse, csa_calc_logic_ready, csa_calc_logic_out,
               csa_calc_logic_cycles
    );
`else
    modport master (
        output csa_calc_logic_request, csa_calc_logic_times, csa_calc_logic_delay,
               csa_calc_logic_in, csa_calc_logic_reset,
        input  csa_calc_logic_inuse, csa_calc_logic_ready, csa_calc_logic_out
    );
    modport slave (
        input  csa_calc_logic_request, csa_calc_logic_times, csa_calc_logic_delay,
               csa_calc_logic_in, csa_calc_logic_reset,
        output csa_calc_logic_inuse, csa_calc_logic_ready, csa_calc_logic_out
    );
`endif
endinterface

// File: rtl/csa_calc_responder.sv
// csa_calc responder: latches a request, runs `times` accumulate rounds spaced by `delay`
// idle cycles, then holds the result until released. Optional macro: CSA_CALC_CYCLE_COUNT_EN.
`timescale 1ns/1ps
module csa_calc_responder #(
    parameter int AXI_DATA_WIDTH     = 32,
    parameter int ID                 = 8,
    parameter int CSA_CALC_IN_WIDTH  = 40,
    parameter int CSA_CALC_OUT_WIDTH = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    csa_calc_responder_if.slave   bus
);
    localparam int OW = CSA_CALC_OUT_WIDTH;
    localparam int IW = CSA_CALC_IN_WIDTH;
    localparam int AW = AXI_DATA_WIDTH;
    localparam logic [7:0] ID_BYTE = 8'(ID);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    r_state;
    logic [IW-1:0] r_in;
    logic [AW-1:0] r_times;
    logic [AW-1:0] r_delay;
    logic [AW-1:0] r_rcnt;
    logic [AW-1:0] r_dcnt;
    logic [OW-1:0] r_acc;
    logic [OW-1:0] r_out;
    logic          r_inuse;
    logic          r_ready;

    logic [AW-1:0] w_rcnt_nxt;
    logic [AW-1:0] w_dcnt_nxt;
    logic [OW-1:0] w_acc_nxt;
    logic [OW-1:0] w_seed;

    // One accumulate round: zero-extended input added modulo 2^OW.
    function automatic logic [OW-1:0] f_acc_add(input logic [OW-1:0] acc, input logic [IW-1:0] x);
        return acc + OW'(x);
    endfunction

    assign w_rcnt_nxt = r_rcnt + 1'b1;
    assign w_dcnt_nxt = r_dcnt + 1'b1;
    assign w_acc_nxt  = f_acc_add(r_acc, r_in);
    assign w_seed     = {ID_BYTE, bus.csa_calc_logic_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_in    <= '0;
            r_times <= '0;
            r_delay <= '0;
            r_rcnt  <= '0;
            r_dcnt  <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_inuse <= 1'b0;
            r_ready <= 1'b0;
        end else if (bus.csa_calc_logic_reset) begin
            // Release/abort wins over everything; the result register keeps its last value.
            r_state <= S_IDLE;
            r_inuse <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.csa_calc_logic_request) begin
                        r_in    <= bus.csa_calc_logic_in;
                        r_times <= bus.csa_calc_logic_times;
                        r_delay <= bus.csa_calc_logic_delay;
                        r_acc   <= w_seed;
                        r_rcnt  <= '0;
                        r_inuse <= 1'b1;
                        if (bus.csa_calc_logic_times == '0) begin
                            r_state <= S_DONE;
                            r_out   <= w_seed;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_acc  <= w_acc_nxt;
                    r_rcnt <= w_rcnt_nxt;
                    if (w_rcnt_nxt == r_times) begin
                        r_state <= S_DONE;
                        r_out   <= w_acc_nxt;
                        r_ready <= 1'b1;
                    end else if (r_delay != '0) begin
                        r_state <= S_WAIT;
                        r_dcnt  <= '0;
                    end
                end
                S_WAIT: begin
                    r_dcnt <= w_dcnt_nxt;
                    if (w_dcnt_nxt == r_delay) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_DONE;
                end
            endcase
        end
    end

    assign bus.csa_calc_logic_inuse = r_inuse;
    assign bus.csa_calc_logic_ready = r_ready;
    assign bus.csa_calc_logic_out   = r_out;

`ifdef CSA_CALC_CYCLE_COUNT_EN
    logic [AW-1:0] r_cycles;

    // Counts busy cycles of the current job; cleared when a job is accepted, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycles <= '0;
        end else if (r_state == S_IDLE && bus.csa_calc_logic_request && !bus.csa_calc_logic_reset) begin
            r_cycles <= '0;
        end else if ((r_state == S_RUN || r_state == S_WAIT) && r_cycles != '1) begin
            r_cycles <= r_cycles + 1'b1;
        end
    end

    assign bus.csa_calc_logic_cycles = r_cycles;
`endif
endmodule

// File: tb/tb_csa_calc_responder.sv
// Directed bench for csa_calc_responder: table of hand-computed jobs plus abort,
// request-spam, request/reset collision, async-reset and back-to-back sequences.
`timescale 1ns/1ps
module tb_csa_calc_responder;
    localparam int LIMIT = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    csa_calc_responder_if #(
        .AXI_DATA_WIDTH(32), .CSA_CALC_IN_WIDTH(40), .CSA_CALC_OUT_WIDTH(48)
    ) bus ();

    csa_calc_responder #(
        .AXI_DATA_WIDTH(32), .ID(8), .CSA_CALC_IN_WIDTH(40), .CSA_CALC_OUT_WIDTH(48)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [39:0] din;
        logic [31:0] times;
        logic [31:0] delay;
        logic [47:0] out;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Issues one request and waits for ready; lat counts edges from the sampling edge.
    task automatic do_req(input logic [39:0] din, input logic [31:0] t, input logic [31:0] d,
                          input bit spam, output int lat);
        int bad_inuse;
        bad_inuse = 0;
        @(negedge clk);
        bus.csa_calc_logic_in      = din;
        bus.csa_calc_logic_times   = t;
        bus.csa_calc_logic_delay   = d;
        bus.csa_calc_logic_request = 1'b1;
        @(posedge clk); #1;
        bus.csa_calc_logic_request = 1'b0;
        lat = 1;
        while (!bus.csa_calc_logic_ready && lat < LIMIT) begin
            if (!bus.csa_calc_logic_inuse) bad_inuse++;
            if (spam) begin
                bus.csa_calc_logic_request = lat[0];
                bus.csa_calc_logic_in      = 40'(($urandom << 8) | 32'hFF);
                bus.csa_calc_logic_times   = 32'd1;
                bus.csa_calc_logic_delay   = 32'd0;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.csa_calc_logic_request = 1'b0;
        chk("inuse_during_job", 64'(bad_inuse), 64'd0);
        chk("inuse_at_ready", 64'(bus.csa_calc_logic_inuse), 64'd1);
    endtask

    task automatic release_job(input logic [47:0] held);
        @(negedge clk);
        bus.csa_calc_logic_reset = 1'b1;
        @(posedge clk); #1;
        bus.csa_calc_logic_reset = 1'b0;
        chk("release_ready", 64'(bus.csa_calc_logic_ready), 64'd0);
        chk("release_inuse", 64'(bus.csa_calc_logic_inuse), 64'd0);
        chk("release_out_held", 64'(bus.csa_calc_logic_out), 64'(held));
    endtask

    task automatic job(input vec_t v, input bit spam, input string nm);
        int lat;
        do_req(v.din, v.times, v.delay, spam, lat);
        chk({nm, "_lat"}, 64'(lat), 64'(v.lat));
        chk({nm, "_out"}, 64'(bus.csa_calc_logic_out), 64'(v.out));
`ifdef CSA_CALC_CYCLE_COUNT_EN
        chk({nm, "_cycles"}, 64'(bus.csa_calc_logic_cycles), 64'(v.lat - 1));
`endif
        release_job(v.out);
    endtask

    initial begin
        vec_t v;
        int   lat;
        vecs[0] = '{40'h1111111111, 32'd100, 32'd0, 48'h0EBBBBBBBBB5, 101};
        vecs[1] = '{40'h1111111111, 32'd0,   32'd0, 48'h081111111111, 1};
        vecs[2] = '{40'h0000000001, 32'd3,   32'd2, 48'h080000000004, 8};
        vecs[3] = '{40'hFFFFFFFFFF, 32'd2,   32'd1, 48'h0AFFFFFFFFFD, 4};
        vecs[4] = '{40'hFFFFFFFFFF, 32'd256, 32'd0, 48'h08FFFFFFFEFF, 257};
        vecs[5] = '{40'h0000000005, 32'd1,   32'd7, 48'h08000000000A, 2};
        vecs[6] = '{40'h123456789A, 32'd5,   32'd1, 48'h086D3A06D39C, 10};

        bus.csa_calc_logic_request = 1'b0;
        bus.csa_calc_logic_reset   = 1'b0;
        bus.csa_calc_logic_in      = '0;
        bus.csa_calc_logic_times   = '0;
        bus.csa_calc_logic_delay   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_inuse", 64'(bus.csa_calc_logic_inuse), 64'd0);
        chk("rst_ready", 64'(bus.csa_calc_logic_ready), 64'd0);
        chk("rst_out", 64'(bus.csa_calc_logic_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            job(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Abort at round 10 of a 100-round job, then a fresh single-round job.
        @(negedge clk);
        bus.csa_calc_logic_in      = 40'h1111111111;
        bus.csa_calc_logic_times   = 32'd100;
        bus.csa_calc_logic_delay   = 32'd0;
        bus.csa_calc_logic_request = 1'b1;
        @(posedge clk); #1;
        bus.csa_calc_logic_request = 1'b0;
        repeat (10) @(posedge clk);
        release_job(vecs[6].out);
        @(posedge clk); #1;
        chk("abort_idle_inuse", 64'(bus.csa_calc_logic_inuse), 64'd0);
        v = '{40'h0000000022, 32'd1, 32'd0, 48'h080000000044, 2};
        job(v, 1'b0, "after_abort");

        // Request spam with changing operands while busy must not disturb the latched job.
        v = '{40'h0000000010, 32'd4, 32'd1, 48'h080000000050, 8};
        job(v, 1'b1, "spam");

        // Request and release together in IDLE: the request is dropped.
        @(negedge clk);
        bus.csa_calc_logic_in      = 40'h77;
        bus.csa_calc_logic_times   = 32'd0;
        bus.csa_calc_logic_request = 1'b1;
        bus.csa_calc_logic_reset   = 1'b1;
        @(posedge clk); #1;
        bus.csa_calc_logic_request = 1'b0;
        bus.csa_calc_logic_reset   = 1'b0;
        chk("collide_inuse", 64'(bus.csa_calc_logic_inuse), 64'd0);
        @(posedge clk); #1;
        chk("collide_inuse2", 64'(bus.csa_calc_logic_inuse), 64'd0);
        chk("collide_ready", 64'(bus.csa_calc_logic_ready), 64'd0);

        // Asynchronous reset in the middle of a WAIT phase.
        @(negedge clk);
        bus.csa_calc_logic_in      = 40'h1;
        bus.csa_calc_logic_times   = 32'd3;
        bus.csa_calc_logic_delay   = 32'd5;
        bus.csa_calc_logic_request = 1'b1;
        @(posedge clk); #1;
        bus.csa_calc_logic_request = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_inuse", 64'(bus.csa_calc_logic_inuse), 64'd0);
        chk("arst_ready", 64'(bus.csa_calc_logic_ready), 64'd0);
        chk("arst_out", 64'(bus.csa_calc_logic_out), 64'd0);
`ifdef CSA_CALC_CYCLE_COUNT_EN
        chk("arst_cycles", 64'(bus.csa_calc_logic_cycles), 64'd0);
`endif
        #1 rst = 1'b0;
        v = '{40'h0000000003, 32'd2, 32'd0, 48'h080000000009, 3};
        job(v, 1'b0, "post_arst");

        // Back-to-back jobs with an incrementing input word.
        for (int k = 0; k < 4; k++) begin
            v.din   = 40'h100 + 40'(k);
            v.times = 32'd2;
            v.delay = 32'd1;
            v.out   = 48'h080000000300 + 48'(3 * k);
            v.lat   = 4;
            job(v, 1'b0, $sformatf("b2b%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
